// File: rtl/usbfs_pkg.sv
// Shared USB full-speed constants: PIDs, CRC16 parameters and transmit state encoding.
// The SYNC state exists only when USBFS_TX_SYNC_EN is defined.
package usbfs_pkg;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  // Reflected forms operate on an LSB-first shift register; residual is in that same order.
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
`ifdef USBFS_TX_SYNC_EN
    ST_SYNC   = 3'd1,
`endif
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5
  } tx_state_e;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/usbfs_tx_pkt_if.sv
// Handshake bundle of the packet-assembly stage: request, endpoint buffer write and serializer byte stream.
interface usbfs_tx_pkt_if #(
  parameter int MAX_PKT = 8
) ();
  localparam int IDX_W = $clog2(MAX_PKT);

  logic             i_pktValid;
  logic             o_pktReady;
  logic [3:0]       i_pktPid;
  logic             o_etTxAccepted;
  logic             i_etWrEn;
  logic [IDX_W-1:0] i_etWrIdx;
  logic [7:0]       i_etWrByte;
  logic             o_txValid;
  logic             i_txReady;
  logic [7:0]       o_txData;
  logic             o_txLast;

  modport master (
    output i_pktValid, i_pktPid, i_etWrEn, i_etWrIdx, i_etWrByte, i_txReady,
    input  o_pktReady, o_etTxAccepted, o_txValid, o_txData, o_txLast
  );

  modport slave (
    input  i_pktValid, i_pktPid, i_etWrEn, i_etWrIdx, i_etWrByte, i_txReady,
    output o_pktReady, o_etTxAccepted, o_txValid, o_txData, o_txLast
  );
endinterface

// File: rtl/usbfs_crc16.sv
// Byte-wide combinational USB CRC16 update (reflected 0x8005), shared with the receive path.
module usbfs_crc16
  import usbfs_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  logic [15:0] c_s;

  always_comb begin
    c_s = crc_i;
    for (int b = 0; b < 8; b++) begin
      if (c_s[0] ^ byte_i[b]) begin
        c_s = (c_s >> 1) ^ CRC16_POLY_REFL;
      end else begin
        c_s = c_s >> 1;
      end
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/usbfs_tx_pkt.sv
// USB FS packet assembly: PID byte, then for DATA PIDs the buffered payload and inverted CRC16.
// Define USBFS_TX_SYNC_EN to emit a 0x80 SYNC byte ahead of the PID.
module usbfs_tx_pkt
  import usbfs_pkg::*;
#(
  parameter int MAX_PKT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  usbfs_tx_pkt_if.slave bus
);

  localparam int              IDX_W   = $clog2(MAX_PKT);
  localparam logic [IDX_W:0]  LEN_MAX = (IDX_W+1)'(MAX_PKT);
  localparam logic [IDX_W:0]  LEN_ONE = (IDX_W+1)'(1);

  tx_state_e        state_q, state_d;
  logic [3:0]       pid_q;
  logic             is_data_q;
  logic [7:0]       buf_q [MAX_PKT];
  logic [IDX_W:0]   len_q, rd_q;
  logic             cap_act_q, cap_done_q, acc_q;
  logic [15:0]      crc_q, crc_nxt_s;
  logic [7:0]       pay_byte_s, tx_data_s;
  logic             tx_valid_s, tx_last_s, accept_s, xfer_s;

  assign accept_s   = bus.i_pktValid && (state_q == ST_IDLE);
  assign xfer_s     = tx_valid_s && bus.i_txReady;
  assign pay_byte_s = buf_q[rd_q[IDX_W-1:0]];

  usbfs_crc16 u_crc (
    .crc_i  (crc_q),
    .byte_i (pay_byte_s),
    .crc_o  (crc_nxt_s)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef USBFS_TX_SYNC_EN
          state_d = ST_SYNC;
`else
          state_d = ST_PID;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef USBFS_TX_SYNC_EN
      ST_SYNC:   state_d = xfer_s ? ST_PID : ST_SYNC;
`endif
      ST_PID: begin
        if (xfer_s) state_d = is_data_q ? ST_DATA : ST_IDLE;
        else        state_d = ST_PID;
      end
      ST_DATA: begin
        if (cap_done_q && (len_q == '0))              state_d = ST_CRC_LO;
        else if (xfer_s && (rd_q == (len_q - LEN_ONE))) state_d = ST_CRC_LO;
        else                                          state_d = ST_DATA;
      end
      ST_CRC_LO: state_d = xfer_s ? ST_CRC_HI : ST_CRC_LO;
      ST_CRC_HI: state_d = xfer_s ? ST_IDLE : ST_CRC_HI;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    tx_last_s  = 1'b0;
    case (state_q)
`ifdef USBFS_TX_SYNC_EN
      ST_SYNC: begin
        tx_valid_s = 1'b1;
        tx_data_s  = SYNC_BYTE;
      end
`endif
      ST_PID: begin
        tx_valid_s = 1'b1;
        tx_data_s  = {~pid_q, pid_q};
        tx_last_s  = ~is_data_q;
      end
      ST_DATA: begin
        tx_valid_s = cap_done_q && (len_q != '0);
        tx_data_s  = tx_valid_s ? pay_byte_s : 8'h00;
      end
      ST_CRC_LO: begin
        tx_valid_s = 1'b1;
        tx_data_s  = ~crc_q[7:0];
      end
      ST_CRC_HI: begin
        tx_valid_s = 1'b1;
        tx_data_s  = ~crc_q[15:8];
        tx_last_s  = 1'b1;
      end
      default: begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        tx_last_s  = 1'b0;
      end
    endcase
  end

  // Request latch, capture tracking, read index and running CRC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pid_q      <= 4'h0;
      is_data_q  <= 1'b0;
      len_q      <= '0;
      rd_q       <= '0;
      cap_act_q  <= 1'b0;
      cap_done_q <= 1'b0;
      acc_q      <= 1'b0;
      crc_q      <= CRC16_INIT;
    end else begin
      acc_q <= (state_q == ST_PID) && xfer_s;
      if (accept_s) begin
        pid_q      <= bus.i_pktPid;
        is_data_q  <= is_data_pid(bus.i_pktPid);
        len_q      <= '0;
        rd_q       <= '0;
        cap_act_q  <= 1'b0;
        cap_done_q <= 1'b0;
        crc_q      <= CRC16_INIT;
      end else begin
        // Capture window opens the cycle after the accepted pulse and closes on the first idle write strobe.
        if (acc_q && is_data_q) begin
          cap_act_q <= 1'b1;
        end else if (cap_act_q && !bus.i_etWrEn) begin
          cap_act_q  <= 1'b0;
          cap_done_q <= 1'b1;
        end
        if (cap_act_q && bus.i_etWrEn && (len_q != LEN_MAX)) len_q <= len_q + LEN_ONE;
        if ((state_q == ST_DATA) && xfer_s) begin
          rd_q  <= rd_q + LEN_ONE;
          crc_q <= crc_nxt_s;
        end
      end
    end
  end

  // Payload buffer, writable at any time
  always_ff @(posedge i_clk) begin
    if (bus.i_etWrEn) buf_q[bus.i_etWrIdx] <= bus.i_etWrByte;
  end

  assign bus.o_pktReady     = (state_q == ST_IDLE);
  assign bus.o_etTxAccepted = acc_q;
  assign bus.o_txValid      = tx_valid_s;
  assign bus.o_txData       = tx_data_s;
  assign bus.o_txLast       = tx_last_s;

endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// Bench for usbfs_tx_pkt: a byte-queue model of each packet checked against the DUT every cycle.
module tb_usbfs_tx_pkt;

  localparam int MAX_PKT = 8;
  localparam int IDX_W   = 3;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       is_pid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vecs  = 0;
  int   fails = 0;

  exp_t       expq[$];
  logic [7:0] mbuf [MAX_PKT];
  logic [7:0] wr_data [16];
  bit         busy = 0, acc_exp = 0, hold = 0, chk_en = 0, rnd_mode = 0;

  usbfs_tx_pkt_if #(.MAX_PKT(MAX_PKT)) bus ();

  usbfs_tx_pkt #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  function automatic bit pid_is_data(input logic [3:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

  // Normal MSB-first CRC over the LSB-first bit stream, then reflected and inverted.
  function automatic logic [15:0] model_crc(input logic [7:0] msg[$]);
    logic [15:0] r, refl;
    logic        fb;
    r = 16'hFFFF;
    foreach (msg[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ msg[k][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int b = 0; b < 16; b++) refl[b] = r[15-b];
    return ~refl;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_txValid", {15'd0, bus.o_txValid}, 16'd0);
    check("rst_txData", {8'd0, bus.o_txData}, 16'd0);
    check("rst_txLast", {15'd0, bus.o_txLast}, 16'd0);
    check("rst_pktReady", {15'd0, bus.o_pktReady}, 16'd1);
    check("rst_accepted", {15'd0, bus.o_etTxAccepted}, 16'd0);
  endtask

  // Per-cycle comparison against the expected byte queue
  always @(negedge clk) begin
    if (chk_en) begin
      check("pktReady", {15'd0, bus.o_pktReady}, {15'd0, !busy});
      check("etTxAccepted", {15'd0, bus.o_etTxAccepted}, {15'd0, acc_exp});
      acc_exp = 0;
      if (hold) check("valid_held", {15'd0, bus.o_txValid}, 16'd1);
      hold = 0;
      if (bus.o_txValid) begin
        if (expq.size() == 0) begin
          check("spurious_txValid", 16'd1, 16'd0);
        end else begin
          check("txData", {8'd0, bus.o_txData}, {8'd0, expq[0].data});
          check("txLast", {15'd0, bus.o_txLast}, {15'd0, expq[0].last});
          if (bus.i_txReady) begin
            acc_exp = expq[0].is_pid;
            if (expq[0].last) busy = 0;
            void'(expq.pop_front());
          end else begin
            hold = 1;
          end
        end
      end
    end
  end

  // Serializer ready: always high or random stalls
  initial begin
    bus.i_txReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.i_txReady = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send_pkt(input logic [3:0] pid, input int nwr);
    logic [7:0]  pay[$];
    logic [15:0] c;
    int          n;
    bit          got;
    @(posedge clk); #1;
    bus.i_pktValid = 1'b1;
    bus.i_pktPid   = pid;
    @(posedge clk); #1;
`ifdef USBFS_TX_SYNC_EN
    expq.push_back('{8'h80, 1'b0, 1'b0});
`endif
    expq.push_back('{pid_byte(pid), !pid_is_data(pid), 1'b1});
    busy = 1;
    if (!pid_is_data(pid)) begin
      bus.i_pktValid = 1'b0;
      return;
    end
    bus.i_pktPid = 4'hA;  // keeps requesting while busy; must be ignored
    got = 0;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      got = bus.o_etTxAccepted;
    end
    if (!got) begin
      check("accepted_timeout", 16'd0, 16'd1);
      bus.i_pktValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.i_pktValid = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      bus.i_etWrEn   = 1'b1;
      bus.i_etWrIdx  = IDX_W'(i % MAX_PKT);
      bus.i_etWrByte = wr_data[i];
      mbuf[i % MAX_PKT] = wr_data[i];
      @(posedge clk); #1;
    end
    bus.i_etWrEn = 1'b0;
    n = (nwr > MAX_PKT) ? MAX_PKT : nwr;
    for (int i = 0; i < n; i++) pay.push_back(mbuf[i]);
    c = model_crc(pay);
    foreach (pay[i]) expq.push_back('{pay[i], 1'b0, 1'b0});
    expq.push_back('{c[7:0], 1'b0, 1'b0});
    expq.push_back('{c[15:8], 1'b1, 1'b0});
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) check("packet_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    chk_en = 0;
    rst    = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    busy = 0; acc_exp = 0; hold = 0;
    chk_en = 1;
  endtask

  initial begin
    logic [7:0] q[$];
    bit         hit;
    rst = 1'b1;
    bus.i_pktValid = 1'b0; bus.i_pktPid = 4'h0;
    bus.i_etWrEn = 1'b0; bus.i_etWrIdx = '0; bus.i_etWrByte = 8'h00;

    // Model pins
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    check("model_crc_check", model_crc(q), 16'hB4C8);
    q.delete();
    check("model_crc_empty", model_crc(q), 16'h0000);
    check("model_pid_ack", {8'd0, pid_byte(4'h2)}, 16'h00D2);
    check("model_pid_data1", {8'd0, pid_byte(4'hB)}, 16'h004B);
    check("model_pid_data0", {8'd0, pid_byte(4'h3)}, 16'h00C3);

    apply_reset(3);

    send_pkt(4'h2, 0);            // ACK
    wait_idle();
    send_pkt(4'hB, 0);            // DATA1, empty payload
    wait_idle();
    wr_data[0] = 8'h01; wr_data[1] = 8'h02; wr_data[2] = 8'h03;
    send_pkt(4'h3, 3);            // DATA0, 3 bytes
    wait_idle();
    send_pkt(4'hA, 0);            // NAK
    wait_idle();

    rnd_mode = 1;
    for (int i = 0; i < 16; i++) wr_data[i] = 8'($urandom_range(0, 255));
    send_pkt(4'h3, 8);            // full buffer under backpressure
    wait_idle();
    for (int i = 0; i < 16; i++) wr_data[i] = 8'hA0 + 8'(i);
    send_pkt(4'hB, 10);           // overlong burst: length saturates, indices wrap
    wait_idle();
    send_pkt(4'hE, 0);            // STALL under backpressure
    wait_idle();
    rnd_mode = 0;

    // Reset mid-payload, then a clean ACK
    for (int i = 0; i < 16; i++) wr_data[i] = 8'h10 + 8'(i);
    send_pkt(4'h3, 8);
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      hit = (expq.size() <= 7);
    end
    if (!hit) check("midpkt_timeout", 16'd0, 16'd1);
    apply_reset(1);
    send_pkt(4'h2, 0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usbfs_tx_pkt.md
Name: usbfs_tx_pkt

Overview:
- Packet-assembly stage directly downstream of the IN-endpoint transmit block.
- Holds one DATA payload in a flop buffer written through the endpoint write-buffer port (wrEn/wrIdx/wrByte).
- On request, emits a byte stream to the bit-level serializer (NRZI/bit-stuff/EOP): PID byte, then for DATA PIDs the payload and CRC16.
- Pulses tx-accepted to the endpoint when the PID byte leaves.

Parameters:
- MAX_PKT, 8, payload buffer depth in bytes; power of 2, at least 2.
- IDX_W, $clog2(MAX_PKT), write-index width; derived, do not override.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_pktValid  in  1  request to send a packet.
- o_pktReady  out  1  high only in IDLE; request accepted on i_pktValid && o_pktReady.
- i_pktPid  in  4  PID to send; sampled on request accept.
- o_etTxAccepted  out  1  one-cycle pulse when the PID byte is accepted downstream.
- i_etWrEn  in  1  payload buffer write strobe.
- i_etWrIdx  in  IDX_W  payload buffer write index.
- i_etWrByte  in  8  payload buffer write data.
- o_txValid  out  1  byte valid to serializer.
- i_txReady  in  1  serializer accepts byte; transfer = o_txValid && i_txReady.
- o_txData  out  8  byte, LSB transmitted first.
- o_txLast  out  1  final byte of packet; serializer appends EOP.

Behaviour:
- Reset values: o_pktReady=1, o_txValid=0, o_txData=0, o_txLast=0, o_etTxAccepted=0. State=IDLE, length=0, capture flags cleared. Reset mid-packet aborts immediately with no further bytes; buffer contents are don't-care.
- Classification on accept: DATA PID if pid[1:0]==2'b11; otherwise PID-only (handshake or other).
- States:
  - IDLE: on accept, latch pid and go to PID.
  - PID: o_txValid=1, o_txData={~pid,pid}, o_txLast=1 if PID-only. On transfer, pulse o_etTxAccepted next cycle. PID-only → IDLE; DATA → DATA.
  - DATA: first payload byte is presented once capture is complete. Length 0 → CRC_LO. Otherwise stream buf[0..len-1]; o_txData registered from buffer; each transfer advances the read index. After the last payload byte → CRC_LO.
  - CRC_LO then CRC_HI: send low then high byte of the inverted CRC. CRC_HI has o_txLast=1. → IDLE.
- Capture:
  - Starts the cycle after the o_etTxAccepted pulse.
  - Each cycle with i_etWrEn high increments length, saturating at MAX_PKT.
  - Completes on the first cycle from that point with i_etWrEn low. Writes are a contiguous burst or none, so length = burst size (0..MAX_PKT).
  - Writes outside capture still update the buffer but do not change length.
- CRC16:
  - Polynomial 0x8005, reflected (LSB-first), init 0xFFFF, updated per transmitted payload byte.
  - Transmitted value is the ones' complement.
  - Zero-length payload transmits 0x00,0x00.
- o_txValid holds and o_txData/o_txLast stay stable until transfer (no retraction).
- i_pktValid while busy is ignored; o_pktReady=0.

Optional Feature:
- USBFS_TX_SYNC_EN defined: state SYNC precedes PID and sends byte 0x80 (o_txLast=0); o_etTxAccepted is still tied to the PID byte.
- Undefined: no SYNC byte; the serializer generates SYNC itself. The SYNC state and its logic are absent.

Decomposition:
- Shared package/header usbfs_pkg: PID constants (ACK=4'h2, NAK=4'hA, STALL=4'hE, DATA0=4'h3, DATA1=4'hB), CRC16 poly/init/residual constants, state encoding.
- Sub-module usbfs_crc16: byte-wide combinational CRC16 update (crc_in, byte → crc_out), reused by the receive path.

Test Plan:
- ACK request (pid=4'h2), i_txReady=1 → single byte 0xD2 with o_txLast=1; o_etTxAccepted pulses once; o_pktReady high again after 2 cycles.
- DATA1 (pid=4'hB), 0 writes → bytes 0x4B, 0x00, 0x00; last flagged on third byte.
- DATA0, burst of 3 writes {0x01,0x02,0x03} after accept pulse → 0xC3,0x01,0x02,0x03 followed by the CRC16 of the payload (ones' complement, LSB-first, init 0xFFFF), matching a reference-model CRC.
- DATA0 with an 8-byte burst (MAX_PKT=8), random i_txReady stalls → 8 payload bytes in order and stable under backpressure; length saturates; CRC matches model.
- Assert i_rst in the DATA state mid-payload → next cycle o_txValid=0, o_pktReady=1; a following ACK request is sent correctly.
- With USBFS_TX_SYNC_EN: ACK request → 0x80 then 0xD2; o_etTxAccepted aligned to 0xD2.
